// File: rtl/pipeline_accumulator.sv
// Per-lane run accumulator: merges consecutive same-ID entries into one fp32 xyz sum
// with a contribution count; saturating split and done-triggered flush.

module fp32_add (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  output logic [31:0] o_sum
);
  logic        w_sa, w_sb, w_sl, w_ss, w_up;
  logic [7:0]  w_ea, w_eb, w_el, w_es, w_d;
  logic [23:0] w_ma, w_mb, w_ml, w_ms;
  logic [26:0] w_al, w_as, w_mask, w_sh, w_n;
  logic [27:0] w_r;
  logic [8:0]  w_e;
  logic [4:0]  w_p, w_lz, w_shl;
  logic [24:0] w_m;

  always_comb begin
    w_sa   = i_a[31];
    w_sb   = i_b[31] ^ i_sub;
    w_ea   = (i_a[30:23] == 8'd0) ? 8'd1 : i_a[30:23];
    w_eb   = (i_b[30:23] == 8'd0) ? 8'd1 : i_b[30:23];
    w_ma   = {|i_a[30:23], i_a[22:0]};
    w_mb   = {|i_b[30:23], i_b[22:0]};
    w_mask = '0;
    w_shl  = '0;
    w_p    = '0;
    if ({w_ea, w_ma} >= {w_eb, w_mb}) begin
      w_sl = w_sa; w_el = w_ea; w_ml = w_ma;
      w_ss = w_sb; w_es = w_eb; w_ms = w_mb;
    end else begin
      w_sl = w_sb; w_el = w_eb; w_ml = w_mb;
      w_ss = w_sa; w_es = w_ea; w_ms = w_ma;
    end
    w_d  = w_el - w_es;
    w_al = {w_ml, 3'b000};
    w_as = {w_ms, 3'b000};
    // Alignment keeps guard/round bits and folds shifted-out bits into a sticky LSB
    if (w_d > 8'd26) begin
      w_sh = {26'd0, |w_as};
    end else begin
      w_mask = ~({27{1'b1}} << w_d);
      w_sh   = (w_as >> w_d) | {26'd0, |(w_as & w_mask)};
    end
    w_r = (w_sl == w_ss) ? ({1'b0, w_al} + {1'b0, w_sh}) : ({1'b0, w_al} - {1'b0, w_sh});
    for (int unsigned k = 0; k < 27; k++) begin
      if (w_r[k]) w_p = k[4:0];
    end
    w_lz = 5'd26 - w_p;
    if (w_r[27]) begin
      w_n = w_r[27:1] | {26'd0, w_r[0]};
      w_e = {1'b0, w_el} + 9'd1;
    end else begin
      // Left shift stops at exponent 1 so tiny results come out subnormal
      w_shl = ({3'b000, w_lz} < w_el) ? w_lz : 5'(w_el - 8'd1);
      w_n   = w_r[26:0] << w_shl;
      w_e   = {1'b0, w_el} - {4'd0, w_shl};
    end
    w_up = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
    w_m  = {1'b0, w_n[26:3]} + {24'd0, w_up};
    if (w_m[24]) begin
      w_m = w_m >> 1;
      w_e = w_e + 9'd1;
    end
    if (w_r == '0)
      o_sum = {(w_sl == w_ss) ? w_sl : 1'b0, 31'd0};
    else if (w_e >= 9'd255)
      o_sum = {w_sl, 8'hff, 23'd0};
    else
      o_sum = {w_sl, (w_m[23] ? w_e[7:0] : 8'd0), w_m[22:0]};
  end
endmodule

module pipeline_accumulator #(
  parameter int NUM_CH = 2,
  parameter int ID_W   = 17,
  parameter int CNT_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH*(97+ID_W)-1:0] in,
  input  logic                        in_valid,
  input  logic                        done,
  output logic [NUM_CH*(97+ID_W)-1:0] out,
  output logic [NUM_CH*CNT_W-1:0]     out_count,
  output logic                        flush_done,
  output logic                        busy
);
  localparam int E = 97 + ID_W;
  localparam logic [E-1:0]     NULL_E = {{ID_W{1'b0}}, 1'b1, 96'd0};
  localparam logic [CNT_W-1:0] CMAX   = '1;

  logic [NUM_CH-1:0][E-1:0]      w_in;
  logic [NUM_CH-1:0][E-1:0]      r_acc;
  logic [NUM_CH-1:0][CNT_W-1:0]  r_cnt;
  logic [NUM_CH-1:0][E-1:0]      r_out;
  logic [NUM_CH-1:0][CNT_W-1:0]  r_out_cnt;
  logic [NUM_CH-1:0][2:0][31:0]  w_sum;

  assign w_in      = in;
  assign out       = r_out;
  assign out_count = r_out_cnt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    for (genvar k = 0; k < 3; k++) begin : g_axis
      fp32_add u_add (
        .i_a   (r_acc[c][k*32 +: 32]),
        .i_b   (w_in[c][k*32 +: 32]),
        .i_sub (1'b0),
        .o_sum (w_sum[c][k])
      );
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_acc[c]     <= NULL_E;
        r_cnt[c]     <= '0;
        r_out[c]     <= NULL_E;
        r_out_cnt[c] <= '0;
      end
      flush_done <= 1'b0;
    end else begin
      flush_done <= done;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_out[c]     <= NULL_E;
        r_out_cnt[c] <= '0;
        if (done) begin
          if (!r_acc[c][96]) begin
            r_out[c]     <= r_acc[c];
            r_out_cnt[c] <= r_cnt[c];
            r_acc[c]     <= NULL_E;
            r_cnt[c]     <= '0;
          end
        end else if (!in_valid || w_in[c][96]) begin
          r_acc[c] <= r_acc[c];
        end else if (r_acc[c][96]) begin
          r_acc[c] <= w_in[c];
          r_cnt[c] <= CNT_W'(1);
        end else if ((w_in[c][E-1:97] != r_acc[c][E-1:97]) || (r_cnt[c] == CMAX)) begin
          r_out[c]     <= r_acc[c];
          r_out_cnt[c] <= r_cnt[c];
          r_acc[c]     <= w_in[c];
          r_cnt[c]     <= CNT_W'(1);
        end else begin
          r_acc[c] <= {r_acc[c][E-1:97], 1'b0, w_sum[c]};
          r_cnt[c] <= r_cnt[c] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!r_acc[c][96]) busy = 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_accumulator.sv
// Bench for pipeline_accumulator: directed steps then random runs, compared against
// an integer-sum reference model converted to fp32 at emit time.

module tb_pipeline_accumulator;
  localparam int NUM_CH = 2;
  localparam int ID_W   = 17;
  localparam int CNT_W  = 2;
  localparam int E      = 97 + ID_W;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam logic [E-1:0] NULL_E = {{ID_W{1'b0}}, 1'b1, 96'd0};

  logic                    clk = 1'b0;
  logic                    reset, in_valid, done;
  logic [NUM_CH*E-1:0]     in, out;
  logic [NUM_CH*CNT_W-1:0] out_count;
  logic                    flush_done, busy;

  int total = 0;
  int bad   = 0;

  bit s_null [NUM_CH];
  int s_id [NUM_CH], s_x [NUM_CH], s_y [NUM_CH], s_z [NUM_CH];
  bit m_full [NUM_CH];
  int m_id [NUM_CH], m_x [NUM_CH], m_y [NUM_CH], m_z [NUM_CH], m_cnt [NUM_CH];
  logic [E-1:0] exp_out [NUM_CH];
  int exp_cnt [NUM_CH];

  pipeline_accumulator #(.NUM_CH(NUM_CH), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .in_valid   (in_valid),
    .done       (done),
    .out        (out),
    .out_count  (out_count),
    .flush_done (flush_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] int2fp(input int v);
    int a, p;
    logic [31:0] m;
    if (v == 0) return 32'd0;
    a = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if ((a >> i) & 1) p = i;
    m = 32'(a) << (23 - p);
    return {(v < 0), 8'(127 + p), m[22:0]};
  endfunction

  function automatic logic [E-1:0] mk(input int id, input int x, input int y, input int z);
    return {ID_W'(id), 1'b0, int2fp(z), int2fp(y), int2fp(x)};
  endfunction

  task automatic chk(input string tag, input logic [E-1:0] got, input logic [E-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_lane(input int c, input bit nul, input int id, input int x, input int y, input int z);
    s_null[c] = nul; s_id[c] = id; s_x[c] = x; s_y[c] = y; s_z[c] = z;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_full[c] = 0; m_cnt[c] = 0;
      exp_out[c] = NULL_E; exp_cnt[c] = 0;
    end
  endtask

  task automatic load(input int c);
    m_full[c] = 1; m_id[c] = s_id[c];
    m_x[c] = s_x[c]; m_y[c] = s_y[c]; m_z[c] = s_z[c]; m_cnt[c] = 1;
  endtask

  task automatic emit(input int c);
    exp_out[c] = mk(m_id[c], m_x[c], m_y[c], m_z[c]);
    exp_cnt[c] = m_cnt[c];
  endtask

  task automatic model_edge(input bit v, input bit d);
    for (int c = 0; c < NUM_CH; c++) begin
      exp_out[c] = NULL_E; exp_cnt[c] = 0;
      if (d) begin
        if (m_full[c]) emit(c);
        m_full[c] = 0; m_cnt[c] = 0;
      end else if (v && !s_null[c]) begin
        if (!m_full[c]) load(c);
        else if (s_id[c] != m_id[c] || m_cnt[c] == CMAX) begin
          emit(c); load(c);
        end else begin
          m_x[c] += s_x[c]; m_y[c] += s_y[c]; m_z[c] += s_z[c]; m_cnt[c]++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag, input bit d);
    bit any;
    any = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      logic [CNT_W-1:0] gc;
      gc = out_count[c*CNT_W +: CNT_W];
      chk($sformatf("%s_out%0d", tag, c), out[c*E +: E], exp_out[c]);
      chk($sformatf("%s_cnt%0d", tag, c), E'(gc), E'(exp_cnt[c]));
      any |= m_full[c];
    end
    chk({tag, "_flush_done"}, E'(flush_done), E'(d));
    chk({tag, "_busy"}, E'(busy), E'(any));
  endtask

  task automatic step(input string tag, input bit v, input bit d);
    in_valid = v; done = d;
    for (int c = 0; c < NUM_CH; c++)
      in[c*E +: E] = s_null[c] ? NULL_E : mk(s_id[c], s_x[c], s_y[c], s_z[c]);
    model_edge(v, d);
    @(posedge clk); #1;
    check_all(tag, d);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; done = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      set_lane(c, 1, 0, 0, 0, 0);
      in[c*E +: E] = NULL_E;
    end
    model_reset();
    #3;
    check_all("rst", 0);
    #9 reset = 1'b0;

    for (int i = 0; i < 3; i++) step("idle", 0, 0);

    // two same-id entries then an id change
    set_lane(0, 0, 5, 1, 0, 0); step("run_a", 1, 0);
    set_lane(0, 0, 5, 2, 0, 0); step("run_b", 1, 0);
    set_lane(0, 0, 9, 1, 0, 0); step("run_c", 1, 0);
    chk("run_x3", E'(out[31:0]), E'(32'h40400000));
    set_lane(0, 1, 0, 0, 0, 0);
    step("drain", 0, 1);

    // saturation split at CMAX
    for (int i = 0; i < 5; i++) begin
      set_lane(0, 0, 3, 1, 0, 0); step("sat", 1, 0);
    end
    set_lane(0, 0, 6, 1, 1, 1); step("sat_end", 1, 0);

    // flush both lanes
    set_lane(0, 0, 4, 2, -3, 5); set_lane(1, 0, 7, -1, 4, 6); step("fl_a", 1, 0);
    set_lane(0, 0, 4, 1, 1, -7); set_lane(1, 0, 7, 3, 0, 2); step("fl_b", 1, 0);
    step("fl_done", 0, 1);
    step("fl_hold", 0, 1);
    step("fl_idle", 0, 0);

    // done together with valid data: data dropped
    set_lane(0, 0, 2, 5, 5, 5); set_lane(1, 0, 1, 2, 2, 2); step("dv_a", 1, 0);
    set_lane(0, 0, 8, 1, 1, 1); set_lane(1, 0, 8, 1, 1, 1); step("dv_done", 1, 1);
    step("dv_idle", 0, 0);

    // asynchronous reset mid-run
    set_lane(1, 0, 7, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      set_lane(0, 0, 2, 1, 2, 3); step("ar_load", 1, 0);
    end
    set_lane(1, 0, 8, 1, 1, 1); step("ar_emit", 1, 0);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all("ar_async", 0);
    #3 reset = 1'b0;
    set_lane(1, 1, 0, 0, 0, 0);
    set_lane(0, 0, 2, 4, 0, 0); step("ar_new", 1, 0);
    set_lane(0, 0, 3, 4, 0, 0); step("ar_emit2", 1, 0);

    // random runs over a small id set
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        set_lane(c, $urandom_range(0, 5) == 0, int'($urandom_range(1, 3)),
                 int'($urandom_range(0, 14)) - 7, int'($urandom_range(0, 14)) - 7,
                 int'($urandom_range(0, 14)) - 7);
      step("rnd", $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
    end
    step("final_flush", 0, 1);
    step("final_idle", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
